// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings
// and frame layout constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LD_LEN,
    LD_DATA,
    LD_WRITE,
    LD_RUN,
    LD_ERR
  } ld_state_t;

  // Bytes in the length header, and bytes per memory word.
  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_word_assembler.sv
// Collects bytes LSB first into a 32-bit word; word_done flags the byte
// that completes the word.
module byte_word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic [31:0] word_full,
  output logic        word_done
);

  // Value the word register takes if byte_in is accepted this cycle.
  assign word_full = {byte_in, word[31:8]};
  assign word_done = byte_en && (byte_cnt == 2'(HDR_BYTES - 1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= word_full;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed byte
// image into instruction memory, then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        ld_we,
  output logic [31:0] ld_addr,
  output logic [31:0] ld_di,
  output logic [3:0]  ld_be,
  output logic        core_resetb,
  output logic        busy,
  output logic        error
);

  ld_state_t   state, state_nxt;
  logic [31:0] len_q;
  logic [31:0] word_idx;
  logic [31:0] gap_cnt;
  logic        accept, asm_en, asm_clear, asm_done;
  logic        timed, gap_expire;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word, asm_word_full;

  assign rx_ready   = (state == LD_LEN) || (state == LD_DATA) || (state == LD_ERR);
  assign accept     = rx_valid && rx_ready;
  assign asm_en     = accept && !reload && ((state == LD_LEN) || (state == LD_DATA));
  assign timed      = ((state == LD_LEN) && (byte_cnt != 2'd0)) || (state == LD_DATA);
  assign gap_expire = timed && !accept && (gap_cnt == 32'(TIMEOUT - 1));
  assign asm_clear  = reload || gap_expire;

  byte_word_assembler u_asm (
    .clk       (clk),
    .resetb    (resetb),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .byte_cnt  (byte_cnt),
    .word      (asm_word),
    .word_full (asm_word_full),
    .word_done (asm_done)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      LD_LEN: begin
        if (asm_done) begin
          if (asm_word_full == '0)                    state_nxt = LD_RUN;
          else if (asm_word_full > 32'(MAX_WORDS))    state_nxt = LD_ERR;
          else                                        state_nxt = LD_DATA;
        end else if (gap_expire) begin
          state_nxt = LD_ERR;
        end
      end
      LD_DATA: begin
        if (asm_done)        state_nxt = LD_WRITE;
        else if (gap_expire) state_nxt = LD_ERR;
      end
      LD_WRITE: state_nxt = ((word_idx + 32'd1) == len_q) ? LD_RUN : LD_DATA;
      LD_RUN:   state_nxt = LD_RUN;
      LD_ERR:   state_nxt = LD_ERR;
      default:  state_nxt = LD_LEN;
    endcase
    if (reload) state_nxt = LD_LEN;
  end

  // The write strobe is masked by reload so no write escapes in that cycle.
  assign ld_we = (state == LD_WRITE) && !reload;
  assign ld_be = ld_we ? 4'hF : 4'h0;
  assign ld_di = asm_word;
  assign busy  = timed || (state == LD_WRITE);
  assign error = (state == LD_ERR);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= LD_LEN;
      len_q       <= '0;
      word_idx    <= '0;
      gap_cnt     <= '0;
      ld_addr     <= BASE_ADDR;
      core_resetb <= 1'b0;
    end else begin
      state       <= state_nxt;
      core_resetb <= (state == LD_RUN) && !reload;
      if (reload) begin
        len_q    <= '0;
        word_idx <= '0;
        gap_cnt  <= '0;
        ld_addr  <= BASE_ADDR;
      end else begin
        if ((state == LD_LEN) && asm_done) len_q <= asm_word_full;
        if (ld_we) begin
          word_idx <= word_idx + 32'd1;
          ld_addr  <= ld_addr + 32'd4;
        end
        if (!timed || accept) gap_cnt <= '0;
        else                  gap_cnt <= gap_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loading, length limits, timeout,
// reload priority and asynchronous reset.
module tb_prog_loader;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_di;
  logic [3:0]  ld_be;
  logic        core_resetb;
  logic        busy;
  logic        error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_be[$];
  int unsigned wr_cyc[$];
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        crb_prev = 1'b0;

  always #5 clk = ~clk;

  prog_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (1024),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .reload      (reload),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_di       (ld_di),
    .ld_be       (ld_be),
    .core_resetb (core_resetb),
    .busy        (busy),
    .error       (error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and core reset release time, sampled mid-cycle.
  always @(negedge clk) begin
    if (ld_we) begin
      wr_addr.push_back(ld_addr);
      wr_data.push_back(ld_di);
      wr_be.push_back(ld_be);
      wr_cyc.push_back(cyc);
    end
    if (core_resetb && !crb_prev) rise_cyc <= cyc;
    crb_prev <= core_resetb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rdy_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    idle($urandom_range(0, 3));
    send_byte(b);
  endtask

  task automatic pulse_reload();
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    reload   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while resetb is held low.
    #12;
    check("rst_we",   32'(ld_we), 32'd0);
    check("rst_addr", ld_addr, 32'h0);
    check("rst_di",   ld_di, 32'h0);
    check("rst_be",   32'(ld_be), 32'd0);
    check("rst_crb",  32'(core_resetb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err",  32'(error), 32'd0);
    check("rst_rdy",  32'(rx_ready), 32'd1);
    #10 resetb = 1'b1;
    @(posedge clk);
    #1;

    // Two-word frame, back-to-back bytes.
    send_byte(8'h02);
    check("t1_busy_len", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    idle(3);
    check("t1_nwr",   32'(wr_addr.size()), 32'd2);
    check("t1_a0",    wr_addr[0], 32'h0);
    check("t1_d0",    wr_data[0], 32'h1234_5678);
    check("t1_be0",   32'(wr_be[0]), 32'hF);
    check("t1_a1",    wr_addr[1], 32'h4);
    check("t1_d1",    wr_data[1], 32'hDEAD_BEEF);
    check("t1_space", wr_cyc[1] - wr_cyc[0], 32'd5);
    check("t1_rise",  rise_cyc - wr_cyc[1], 32'd2);
    check("t1_crb",   32'(core_resetb), 32'd1);
    check("t1_rdy",   32'(rx_ready), 32'd0);
    check("t1_busy",  32'(busy), 32'd0);

    // Zero-length frame.
    pulse_reload();
    check("t2_crb_rl", 32'(core_resetb), 32'd0);
    send_word(32'h0);
    rx_valid = 1'b0;
    check("t2_crb_e1", 32'(core_resetb), 32'd0);
    @(posedge clk);
    #1;
    check("t2_crb_e2", 32'(core_resetb), 32'd1);
    check("t2_nwr",    32'(wr_addr.size()), 32'd2);

    // Length MAX_WORDS+1.
    pulse_reload();
    send_word(32'd1025);
    rx_valid = 1'b0;
    check("t3_err",  32'(error), 32'd1);
    check("t3_crb",  32'(core_resetb), 32'd0);
    check("t3_rdy",  32'(rx_ready), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    idle(6);
    check("t3_nwr",  32'(wr_addr.size()), 32'd2);
    check("t3_err2", 32'(error), 32'd1);
    check("t3_crb2", 32'(core_resetb), 32'd0);

    // Stall after the 2nd data byte: error exactly after TO idle cycles.
    pulse_reload();
    check("t4_err_clr", 32'(error), 32'd0);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TO - 1);
    check("t4_err_pre",  32'(error), 32'd0);
    check("t4_busy_pre", 32'(busy), 32'd1);
    idle(1);
    check("t4_err",  32'(error), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    idle(4);
    check("t4_nwr",  32'(wr_addr.size()), 32'd2);

    // Recovery frame with a gap of TO-1 cycles, just short of the limit.
    pulse_reload();
    check("t4_err_rl", 32'(error), 32'd0);
    send_word(32'd1);
    send_byte(8'h44);
    idle(TO - 1);
    send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    idle(3);
    check("t4r_nwr", 32'(wr_addr.size()), 32'd3);
    check("t4r_a",   wr_addr[2], 32'h0);
    check("t4r_d",   wr_data[2], 32'h1122_3344);
    check("t4r_err", 32'(error), 32'd0);
    check("t4r_crb", 32'(core_resetb), 32'd1);

    // Reload from RUN, then reload colliding with an accepted byte.
    pulse_reload();
    check("t5_crb",  32'(core_resetb), 32'd0);
    check("t5_rdy",  32'(rx_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("t5_rl_byte", 32'(busy), 32'd0);
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    idle(3);
    check("t5_nwr", 32'(wr_addr.size()), 32'd4);
    check("t5_a",   wr_addr[3], 32'h0);
    check("t5_d",   wr_data[3], 32'hCAFE_F00D);
    check("t5_crb2", 32'(core_resetb), 32'd1);

    // Reload arriving in the WRITE cycle suppresses the write.
    pulse_reload();
    send_word(32'd2);
    send_word(32'h0102_0304);
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    check("t5w_nwr",  32'(wr_addr.size()), 32'd4);
    check("t5w_busy", 32'(busy), 32'd0);
    send_word(32'd1);
    send_word(32'h0BAD_C0DE);
    idle(3);
    check("t5w_nwr2", 32'(wr_addr.size()), 32'd5);
    check("t5w_a",    wr_addr[4], 32'h0);
    check("t5w_d",    wr_data[4], 32'h0BAD_C0DE);

    // Asynchronous reset in the middle of the second word.
    pulse_reload();
    send_word(32'd2);
    send_byte_gap(8'hD4); send_byte_gap(8'hC3);
    send_byte_gap(8'hB2); send_byte_gap(8'hA1);
    send_byte_gap(8'h99);
    idle(1);
    check("t6_nwr",   32'(wr_addr.size()), 32'd6);
    check("t6_d0",    wr_data[5], 32'hA1B2_C3D4);
    check("t6_addr",  ld_addr, 32'h4);
    check("t6_busy",  32'(busy), 32'd1);
    #3 resetb = 1'b0;
    #1;
    check("t6r_we",   32'(ld_we), 32'd0);
    check("t6r_addr", ld_addr, 32'h0);
    check("t6r_di",   ld_di, 32'h0);
    check("t6r_be",   32'(ld_be), 32'd0);
    check("t6r_crb",  32'(core_resetb), 32'd0);
    check("t6r_busy", 32'(busy), 32'd0);
    check("t6r_err",  32'(error), 32'd0);
    check("t6r_rdy",  32'(rx_ready), 32'd1);
    #12 resetb = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'd1);
    send_word(32'h5A5A_A5A5);
    idle(3);
    check("t6f_nwr", 32'(wr_addr.size()), 32'd7);
    check("t6f_a",   wr_addr[6], 32'h0);
    check("t6f_d",   wr_data[6], 32'h5A5A_A5A5);
    check("t6f_crb", 32'(core_resetb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time sequencer for the RV32I core.
- Holds the core in reset, receives a program image as a byte stream, assembles little-endian 32-bit words, and writes them into instruction memory through the MMU loader write port.
- Releases the core's reset once the image is complete.
- Sits between the external byte link (UART receiver) and the MMU/core, at top level next to core.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first word written; must be word aligned.
- MAX_WORDS, 1024, largest word count accepted.
- TIMEOUT, 65535, idle cycles allowed between bytes once a frame has started.

Ports:
- clk  input  1  core clock
- resetb  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte; transfer when rx_valid & rx_ready
- reload  input  1  one-cycle pulse; restart loading from any state
- ld_we  output  1  memory write strobe, one cycle per word
- ld_addr  output  32  word write byte address
- ld_di  output  32  write data
- ld_be  output  4  byte enables; 4'hF when ld_we, else 4'h0
- core_resetb  output  1  reset to core, active low
- busy  output  1  frame in progress (LEN with >=1 byte, DATA, WRITE)
- error  output  1  sticky until reload or resetb

Behaviour:
- Clock and reset: one clock, clk. resetb is asynchronous, active low.
- Reset values: state=LEN, byte_cnt=0, word_idx=0, gap counter=0. Outputs: ld_we=0, ld_addr=BASE_ADDR, ld_di=0, ld_be=0, core_resetb=0, busy=0, error=0, rx_ready=1 after reset deasserts.
- Frame format: 4-byte word count N (LSB first), then N words, each LSB first.
- LEN state:
  - rx_ready=1.
  - Each accepted byte shifts into len[8*byte_cnt+:8].
  - After the 4th byte: N==0 -> RUN; N>MAX_WORDS -> ERR; else -> DATA.
- DATA state:
  - rx_ready=1.
  - Bytes fill the word register LSB first.
  - On the 4th byte -> WRITE next cycle.
- WRITE state (exactly one cycle):
  - rx_ready=0, ld_we=1, ld_be=4'hF.
  - ld_addr = BASE_ADDR + {word_idx,2'b00}; ld_di = assembled word.
  - Then word_idx++. If word_idx+1==N -> RUN, else -> DATA.
- Write outputs: ld_addr and ld_di are registered and stable during ld_we. Max throughput is 1 word per 5 cycles.
- RUN state:
  - rx_ready=0.
  - core_resetb is a registered output, 1 only while in RUN. It rises on the first clock after entering RUN, so at least one cycle after the last ld_we.
- ERR state:
  - error=1, core_resetb=0.
  - rx_ready=1; bytes are drained and discarded.
- Timeout:
  - In LEN (byte_cnt>0) or DATA, the gap counter increments each cycle with no accepted byte and clears on acceptance.
  - Reaching TIMEOUT -> ERR.
  - No timeout applies in LEN with byte_cnt==0, i.e. waiting for a frame.
- reload:
  - Highest priority, overriding any byte accepted the same cycle.
  - Next state is LEN. Clears counters and error; core_resetb=0 from the next edge.
  - A write is never emitted in the reload cycle.
- Address arithmetic: 32-bit, wraps modulo 2^32. No overflow check beyond MAX_WORDS.
- Mid-operation resetb assertion: all state returns to reset values immediately (asynchronous). Partially loaded memory is not cleared.

Decomposition:
- Shared package/header (alongside the existing core headers):
  - state encodings LD_LEN, LD_DATA, LD_WRITE, LD_RUN, LD_ERR
  - frame header size constant (4 bytes)
- One natural sub-module, byte_word_assembler: byte counter plus LSB-first shift register, with a word_done pulse and clear input. All FSM logic stays in prog_loader.

Test Plan:
- Length 2, bytes 78 56 34 12 EF BE AD DE, rx_valid held high -> ld_we pulses at addr 0 data 32'h12345678 and addr 4 data 32'hDEADBEEF. Each pulse lasts 1 cycle, with 5-cycle spacing. core_resetb rises 1 cycle after the second write.
- Length 0 (00 00 00 00) -> no ld_we; core_resetb=1 the second edge after the 4th byte.
- Length MAX_WORDS+1 -> error=1, core_resetb stays 0, rx_ready=1. Subsequent bytes produce no writes.
- Frame of 1 word, stall of TIMEOUT cycles after the 2nd data byte -> error=1, no ld_we. reload then a valid 1-word frame -> error clears, write at BASE_ADDR, core_resetb=1.
- In RUN, pulse reload -> core_resetb=0 next edge, rx_ready=1, word_idx restarts. A new 1-word frame writes at BASE_ADDR again.
- Assert resetb mid-DATA, random rx_valid gaps -> all outputs at reset values asynchronously. After release, a fresh frame loads correctly.
